// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART types and parity helper shared by transmitter and receiver
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

    // Payloads narrower than 8 bits arrive zero-extended, which leaves the XOR unchanged
    function automatic logic parityBit(parity_e mode, logic [7:0] payload);
        return (mode == PAR_ODD) ? ~(^payload) : ^payload;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO, rdata valid whenever empty is low
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    // full is judged on the pre-pop occupancy, so a pop never rescues a write to a full FIFO
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign full   = (level == LW'(DEPTH));
    assign empty  = (level == '0);
    assign rdata  = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            if (doPush && !doPop) begin
                level <= level + LW'(1);
            end else if (doPop && !doPush) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with configurable frame format
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int      DIVISOR    = 2500,
    parameter int      DATA_BITS  = 8,
    parameter parity_e PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [DATA_BITS-1:0]              wdata,
    input  logic                              we,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic                              busy,
    output logic                              overflow,
    output logic                              uartTxPin
);

    localparam int              BW        = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(DIVISOR - 1);
    localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

    if (DIVISOR < 2) begin : gBadDivisor
        $error("uart_tx_fifo: DIVISOR must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : gBadDataBits
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end

    tx_state_e            state;
    tx_state_e            stateNext;
    logic [BW-1:0]        baudCnt;
    logic [BW-1:0]        baudNext;
    logic [2:0]           bitCnt;
    logic [2:0]           bitNext;
    logic [DATA_BITS-1:0] shiftReg;
    logic [DATA_BITS-1:0] shiftNext;
    logic [DATA_BITS-1:0] headData;
    logic                 parReg;
    logic                 parNext;
    logic                 txNext;
    logic                 pop;
    logic                 bitEnd;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) fifo (
        .clock (clock),
        .reset (reset),
        .push  (we),
        .pop   (pop),
        .wdata (wdata),
        .rdata (headData),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign bitEnd = (baudCnt == BAUD_LAST);
    assign busy   = (state != IDLE) || !empty;

    always_comb begin
        stateNext = state;
        baudNext  = (state == IDLE || bitEnd) ? '0 : baudCnt + BW'(1);
        bitNext   = bitCnt;
        shiftNext = shiftReg;
        parNext   = parReg;
        pop       = 1'b0;
        txNext    = 1'b1;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                end
            end
            START: begin
                if (bitEnd) begin
                    stateNext = DATA;
                    bitNext   = '0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shiftNext = shiftReg >> 1;
                    if (bitCnt == DATA_LAST) begin
                        stateNext = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
                        bitNext   = '0;
                    end else begin
                        bitNext = bitCnt + 3'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (bitEnd) begin
                    stateNext = STOP;
                    bitNext   = '0;
                end
            end
            STOP: begin
                if (bitEnd) begin
                    bitNext = bitCnt + 3'd1;
                    if (bitCnt == STOP_LAST) begin
                        bitNext = '0;
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            stateNext = IDLE;
                        end
                    end
                end
            end
            default: stateNext = IDLE;
        endcase

        // A pop from IDLE or from the final stop cycle both launch the next frame directly
        if (pop) begin
            stateNext = START;
            shiftNext = headData;
            parNext   = parityBit(PARITY, 8'(headData));
            bitNext   = '0;
            baudNext  = '0;
        end

        case (stateNext)
            START:            txNext = 1'b0;
            DATA:             txNext = shiftNext[0];
            uart_pkg::PARITY: txNext = parNext;
            default:          txNext = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            baudCnt   <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parReg    <= 1'b0;
            uartTxPin <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            state     <= stateNext;
            baudCnt   <= baudNext;
            bitCnt    <= bitNext;
            shiftReg  <= shiftNext;
            parReg    <= parNext;
            uartTxPin <= txNext;
            overflow  <= we && full;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo over four frame formats
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int      N        = 4;
    localparam int      DEPTH    = 4;
    localparam int      DIVS[N]  = '{4, 4, 3, 4};
    localparam int      DBITS[N] = '{8, 8, 8, 7};
    localparam parity_e PARS[N]  = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE};
    localparam int      STOPS[N] = '{1, 1, 1, 2};

    logic       clock = 1'b0;
    logic       reset;
    logic       we[N];
    logic [7:0] wdata[N];
    logic       full[N];
    logic       empty[N];
    logic       busy[N];
    logic       overflow[N];
    logic       txPin[N];
    logic [2:0] level[N];

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : gDut
        uart_tx_fifo #(
            .DIVISOR    (DIVS[g]),
            .DATA_BITS  (DBITS[g]),
            .PARITY     (PARS[g]),
            .STOP_BITS  (STOPS[g]),
            .FIFO_DEPTH (DEPTH)
        ) dut (
            .clock     (clock),
            .reset     (reset),
            .wdata     (wdata[g][DBITS[g]-1:0]),
            .we        (we[g]),
            .full      (full[g]),
            .empty     (empty[g]),
            .level     (level[g]),
            .busy      (busy[g]),
            .overflow  (overflow[g]),
            .uartTxPin (txPin[g])
        );
    end

    // Reference model: queued bytes, and the expected line level for each upcoming cycle
    logic [7:0] pend[N][$];
    bit         lineQ[N][$];
    bit         expTx[N];
    bit         inFrame[N];
    bit         expOvf[N];
    int         errors = 0;
    int         checks = 0;

    function automatic logic [7:0] mask(int k);
        return 8'((1 << DBITS[k]) - 1);
    endfunction

    function automatic void addFrame(int k, logic [7:0] b);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DBITS[k]; i++) bits.push_back(b[i]);
        if (PARS[k] == PAR_EVEN) bits.push_back(^b);
        if (PARS[k] == PAR_ODD)  bits.push_back(~(^b));
        for (int i = 0; i < STOPS[k]; i++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int r = 0; r < DIVS[k]; r++) lineQ[k].push_back(bits[i]);
        end
    endfunction

    task automatic check(string tag, int k, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] t=%0t observed=%0h expected=%0h", tag, k, $time, obs, exp);
        end
    endtask

    task automatic checkAll(string tag);
        for (int k = 0; k < N; k++) begin
            int sz;
            sz = pend[k].size();
            check({tag, "_tx"},       k, 8'(txPin[k]),    8'(expTx[k]));
            check({tag, "_level"},    k, 8'(level[k]),    8'(sz));
            check({tag, "_full"},     k, 8'(full[k]),     8'(sz == DEPTH));
            check({tag, "_empty"},    k, 8'(empty[k]),    8'(sz == 0));
            check({tag, "_busy"},     k, 8'(busy[k]),     8'(inFrame[k] || sz > 0));
            check({tag, "_overflow"}, k, 8'(overflow[k]), 8'(expOvf[k]));
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < N; k++) begin
            pend[k].delete();
            lineQ[k].delete();
            expTx[k]   = 1'b1;
            inFrame[k] = 1'b0;
            expOvf[k]  = 1'b0;
        end
    endtask

    // One clock: update the model from inputs seen at the edge, then check at the falling edge
    task automatic cycle(string tag);
        @(posedge clock);
        for (int k = 0; k < N; k++) begin
            int cb;
            bit doPop;
            cb    = pend[k].size();
            doPop = (lineQ[k].size() == 0) && (cb > 0);
            expOvf[k] = we[k] && (cb == DEPTH);
            if (we[k] && cb < DEPTH) pend[k].push_back(wdata[k] & mask(k));
            if (doPop) addFrame(k, pend[k].pop_front());
            inFrame[k] = (lineQ[k].size() > 0);
            expTx[k]   = inFrame[k] ? lineQ[k].pop_front() : 1'b1;
        end
        @(negedge clock);
        checkAll(tag);
    endtask

    task automatic idle(string tag, int n);
        repeat (n) cycle(tag);
    endtask

    task automatic put(int k, logic [7:0] d, string tag);
        we[k]    = 1'b1;
        wdata[k] = d;
        cycle(tag);
        we[k]    = 1'b0;
    endtask

    task automatic doReset(string tag);
        #1;
        reset = 1'b0;
        #1;
        clearModel();
        checkAll(tag);
        @(negedge clock);
        @(negedge clock);
        checkAll(tag);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        for (int k = 0; k < N; k++) begin
            we[k]    = 1'b0;
            wdata[k] = 8'h00;
        end
        clearModel();
        repeat (3) @(negedge clock);
        checkAll("reset");
        reset = 1'b1;

        put(0, 8'h55, "n81_55");
        idle("n81_55", 45);
        put(1, 8'h07, "even_07");
        idle("even_07", 45);
        put(2, 8'h07, "odd_07");
        idle("odd_07", 35);
        put(3, 8'h41, "d7s2_41");
        idle("d7s2_41", 50);

        put(0, 8'hA5, "b2b");
        put(0, 8'h3C, "b2b");
        idle("b2b", 85);

        // Eight consecutive writes from idle: five accepted, the last three overflow
        for (int i = 0; i < 8; i++) begin
            we[0]    = 1'b1;
            wdata[0] = 8'(8'h10 + i);
            cycle("burst");
        end
        we[0] = 1'b0;
        idle("burst", 220);

        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                we[k]    = ($urandom_range(0, 3) == 0);
                wdata[k] = 8'($urandom);
            end
            cycle("rand");
        end
        for (int k = 0; k < N; k++) we[k] = 1'b0;
        idle("drain", 250);

        // Three writes, then reset while data bit 3 of the first frame is on the line
        for (int i = 0; i < 3; i++) begin
            we[0]    = 1'b1;
            wdata[0] = 8'(8'hC3 + i);
            cycle("midreset");
        end
        we[0] = 1'b0;
        idle("midreset", 16);
        doReset("abort");
        put(0, 8'hFF, "post_ff");
        idle("post_ff", 45);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
